// File: rtl/apb_arb_pkg.sv
// Shared types for the two-master APB GPIO arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } arb_state_e;

  typedef enum logic {
    GNT_M0,
    GNT_M1
  } arb_gnt_e;

endpackage

// File: rtl/apb_arb_rr2.sv
// Combinational two-way picker: a lone requester wins; on a tie the fixed
// priority favours m0, otherwise the master that did not win last time.
module apb_arb_rr2
  import apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_gnt_e   last,
  input  logic       fixed,
  output arb_gnt_e   gnt
);

  // Select the winner from the current request pair.
  always_comb begin
    gnt = GNT_M0;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = (fixed || (last == GNT_M1)) ? GNT_M0 : GNT_M1;
      default: gnt = GNT_M0;
    endcase
  end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// 2:1 APB arbiter sharing one GPIO slave between m0 (core bus) and m1
// (event/DMA unit). One transfer at a time, with optional access timeout.
module apb_gpio_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] m0_PADDR,
  input  logic [31:0]               m0_PWDATA,
  input  logic                      m0_PWRITE,
  input  logic                      m0_PSEL,
  input  logic                      m0_PENABLE,
  output logic [31:0]               m0_PRDATA,
  output logic                      m0_PREADY,
  output logic                      m0_PSLVERR,
  input  logic [APB_ADDR_WIDTH-1:0] m1_PADDR,
  input  logic [31:0]               m1_PWDATA,
  input  logic                      m1_PWRITE,
  input  logic                      m1_PSEL,
  input  logic                      m1_PENABLE,
  output logic [31:0]               m1_PRDATA,
  output logic                      m1_PREADY,
  output logic                      m1_PSLVERR,
  output logic [APB_ADDR_WIDTH-1:0] s_PADDR,
  output logic [31:0]               s_PWDATA,
  output logic                      s_PWRITE,
  output logic                      s_PSEL,
  output logic                      s_PENABLE,
  input  logic [31:0]               s_PRDATA,
  input  logic                      s_PREADY,
  input  logic                      s_PSLVERR
);

  // Counter is kept at least one bit wide so the timeout-off build still elaborates.
  localparam int unsigned TO_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

  arb_state_e          state;
  arb_state_e          state_nxt;
  arb_gnt_e            gnt;
  arb_gnt_e            last_gnt;
  arb_gnt_e            pick;
  logic [TO_CNT_W-1:0] to_cnt;
  logic                any_req;
  logic                timed_out;
  logic                done;
  logic [31:0]         rsp_data;
  logic                rsp_err;

  apb_arb_rr2 u_rr2 (
    .req   ({m1_PSEL, m0_PSEL}),
    .last  (last_gnt),
    .fixed (FIXED_PRIO != 0),
    .gnt   (pick)
  );

  // Transfer-end conditions: slave ready, or the stall counter hit its limit.
  always_comb begin
    any_req   = m0_PSEL | m1_PSEL;
    timed_out = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && (to_cnt == TO_LIMIT);
    done      = (state == ACCESS) && (timed_out || s_PREADY);
    rsp_data  = timed_out ? '0 : s_PRDATA;
    rsp_err   = timed_out | s_PSLVERR;
  end

  // State, grant, last winner and ACCESS stall counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      gnt      <= GNT_M0;
      last_gnt <= GNT_M1;
      to_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) gnt <= pick;
      if (done) last_gnt <= gnt;
      // Any ACCESS cycle that does not end the transfer is a stalled one.
      if (state == ACCESS && !done) to_cnt <= to_cnt + 1'b1;
      else                          to_cnt <= '0;
    end
  end

  // Next-state sequencing IDLE -> SETUP -> ACCESS -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-side mux and response routing to the granted master.
  always_comb begin
    s_PADDR    = '0;
    s_PWDATA   = '0;
    s_PWRITE   = 1'b0;
    s_PSEL     = 1'b0;
    s_PENABLE  = 1'b0;
    m0_PRDATA  = '0;
    m0_PREADY  = 1'b0;
    m0_PSLVERR = 1'b0;
    m1_PRDATA  = '0;
    m1_PREADY  = 1'b0;
    m1_PSLVERR = 1'b0;
    if (state == SETUP || state == ACCESS) begin
      s_PADDR   = (gnt == GNT_M1) ? m1_PADDR  : m0_PADDR;
      s_PWDATA  = (gnt == GNT_M1) ? m1_PWDATA : m0_PWDATA;
      s_PWRITE  = (gnt == GNT_M1) ? m1_PWRITE : m0_PWRITE;
      s_PSEL    = !timed_out;
      s_PENABLE = (state == ACCESS) && !timed_out;
    end
    // A winner that has already dropped PSEL gets no response.
    if (done && gnt == GNT_M0 && m0_PSEL) begin
      m0_PREADY  = 1'b1;
      m0_PRDATA  = rsp_data;
      m0_PSLVERR = rsp_err;
    end
    if (done && gnt == GNT_M1 && m1_PSEL) begin
      m1_PREADY  = 1'b1;
      m1_PRDATA  = rsp_data;
      m1_PSLVERR = rsp_err;
    end
  end

  a_m0_pen_sel : assert property (@(posedge HCLK) disable iff (!HRESETn) m0_PENABLE |-> m0_PSEL);
  a_m1_pen_sel : assert property (@(posedge HCLK) disable iff (!HRESETn) m1_PENABLE |-> m1_PSEL);
  a_m0_setup   : assert property (@(posedge HCLK) disable iff (!HRESETn) $rose(m0_PSEL) |-> !m0_PENABLE);
  a_m1_setup   : assert property (@(posedge HCLK) disable iff (!HRESETn) $rose(m1_PSEL) |-> !m1_PENABLE);

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Bench for apb_gpio_arbiter: transaction-level reference model checked every
// cycle, directed literal cases, randomized traffic, and a fixed-priority build.
module tb_apb_gpio_arbiter;

  localparam int AW = 12;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin, timeout=4 instance
  logic [AW-1:0] m_addr[2]  = '{default: '0};
  logic [31:0]   m_wdata[2] = '{default: '0};
  logic          m_write[2] = '{default: 1'b0};
  logic          m_psel[2]  = '{default: 1'b0};
  logic          m_pen[2]   = '{default: 1'b0};
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic          s_write, s_psel, s_pen;
  logic [31:0]   s_rdata = '0;
  logic          s_ready = 1'b0;
  logic          s_err   = 1'b0;

  apb_gpio_arbiter #(.APB_ADDR_WIDTH(AW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .m0_PADDR(m_addr[0]), .m0_PWDATA(m_wdata[0]), .m0_PWRITE(m_write[0]),
    .m0_PSEL(m_psel[0]), .m0_PENABLE(m_pen[0]),
    .m0_PRDATA(m0_rdata), .m0_PREADY(m0_ready), .m0_PSLVERR(m0_err),
    .m1_PADDR(m_addr[1]), .m1_PWDATA(m_wdata[1]), .m1_PWRITE(m_write[1]),
    .m1_PSEL(m_psel[1]), .m1_PENABLE(m_pen[1]),
    .m1_PRDATA(m1_rdata), .m1_PREADY(m1_ready), .m1_PSLVERR(m1_err),
    .s_PADDR(s_addr), .s_PWDATA(s_wdata), .s_PWRITE(s_write),
    .s_PSEL(s_psel), .s_PENABLE(s_pen),
    .s_PRDATA(s_rdata), .s_PREADY(s_ready), .s_PSLVERR(s_err)
  );

  // Fixed-priority instance with timeout disabled and a zero-wait slave
  logic          f_psel[2] = '{default: 1'b0};
  logic          f_pen[2]  = '{default: 1'b0};
  logic [31:0]   f_m0_rdata, f_m1_rdata;
  logic          f_m0_ready, f_m1_ready, f_m0_err, f_m1_err;
  logic [AW-1:0] f_s_addr;
  logic [31:0]   f_s_wdata;
  logic          f_s_write, f_s_psel, f_s_pen;

  apb_gpio_arbiter #(.APB_ADDR_WIDTH(AW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)) dut_fp (
    .HCLK(clk), .HRESETn(rst_n),
    .m0_PADDR(12'h010), .m0_PWDATA(32'h0000_0001), .m0_PWRITE(1'b1),
    .m0_PSEL(f_psel[0]), .m0_PENABLE(f_pen[0]),
    .m0_PRDATA(f_m0_rdata), .m0_PREADY(f_m0_ready), .m0_PSLVERR(f_m0_err),
    .m1_PADDR(12'h020), .m1_PWDATA(32'h0000_0002), .m1_PWRITE(1'b0),
    .m1_PSEL(f_psel[1]), .m1_PENABLE(f_pen[1]),
    .m1_PRDATA(f_m1_rdata), .m1_PREADY(f_m1_ready), .m1_PSLVERR(f_m1_err),
    .s_PADDR(f_s_addr), .s_PWDATA(f_s_wdata), .s_PWRITE(f_s_write),
    .s_PSEL(f_s_psel), .s_PENABLE(f_s_pen),
    .s_PRDATA(32'h1234_5678), .s_PREADY(1'b1), .s_PSLVERR(1'b0)
  );

  // Reference model: one outstanding transfer described by owner, start cycle
  // and the slave's wait count; its end point is start + 2 + min(waits, TO).
  int unsigned cyc = 0;
  bit          active = 0;
  int unsigned c0 = 0;
  int          owner = 0;
  int          last = 1;
  int unsigned waits = 0;
  int unsigned k = 0;
  bit          to_hit = 0;
  int unsigned last_done_cyc = 0;
  bit          pend[2] = '{default: 0};
  bit          want[2] = '{default: 0};
  logic [AW-1:0] nxt_addr[2]  = '{default: '0};
  logic [31:0]   nxt_wdata[2] = '{default: '0};
  logic          nxt_write[2] = '{default: 1'b0};
  bit          noise = 0;
  bit          rand_waits = 0;
  int unsigned dir_waits = 0;
  logic [31:0] dir_rdata = '0;
  int          served_q[$];
  int          passes = 0;
  int          total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive masters and slave, evaluate the model, compare.
  task automatic step();
    int unsigned d;
    bit          done;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_write, e_psel, e_pen;
    logic        e_rdy[2];
    logic        e_err[2];
    logic [31:0] e_rd[2];
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (pend[m]) begin
        m_pen[m] = 1'b1;
      end else if (want[m]) begin
        pend[m]    = 1;
        m_psel[m]  = 1'b1;
        m_pen[m]   = 1'b0;
        m_addr[m]  = nxt_addr[m];
        m_wdata[m] = nxt_wdata[m];
        m_write[m] = nxt_write[m];
      end else begin
        m_psel[m] = 1'b0;
        m_pen[m]  = 1'b0;
        if (noise) begin
          m_addr[m]  = AW'($urandom);
          m_wdata[m] = $urandom;
          m_write[m] = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!active && (pend[0] || pend[1])) begin
      active = 1;
      c0     = cyc;
      if (pend[0] && pend[1]) owner = 1 - last;
      else                    owner = pend[1] ? 1 : 0;
      waits  = rand_waits ? $urandom_range(0, 7) : dir_waits;
      to_hit = (waits >= TO);
      k      = to_hit ? TO : waits;
    end
    d = active ? (cyc - c0) : 0;
    if (active && d >= 2) s_ready = ((d - 2) == waits);
    else                  s_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    s_rdata = noise ? $urandom : dir_rdata;
    s_err   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    done    = 0;
    e_addr  = '0;
    e_wdata = '0;
    e_write = 1'b0;
    e_psel  = 1'b0;
    e_pen   = 1'b0;
    e_rdy   = '{default: 1'b0};
    e_err   = '{default: 1'b0};
    e_rd    = '{default: '0};
    if (active && d >= 1) begin
      e_addr  = m_addr[owner];
      e_wdata = m_wdata[owner];
      e_write = m_write[owner];
      e_psel  = 1'b1;
      e_pen   = (d >= 2);
      if (d >= 2 && (d - 2) == k) begin
        done         = 1;
        e_rdy[owner] = 1'b1;
        if (to_hit) begin
          e_psel       = 1'b0;
          e_pen        = 1'b0;
          e_err[owner] = 1'b1;
        end else begin
          e_rd[owner]  = s_rdata;
          e_err[owner] = s_err;
        end
      end
    end
    chk("s_psel", s_psel, e_psel);
    chk("s_penable", s_pen, e_pen);
    chk("s_paddr", s_addr, e_addr);
    chk("s_pwdata", s_wdata, e_wdata);
    chk("s_pwrite", s_write, e_write);
    chk("m0_pready", m0_ready, e_rdy[0]);
    chk("m0_prdata", m0_rdata, e_rd[0]);
    chk("m0_pslverr", m0_err, e_err[0]);
    chk("m1_pready", m1_ready, e_rdy[1]);
    chk("m1_prdata", m1_rdata, e_rd[1]);
    chk("m1_pslverr", m1_err, e_err[1]);
    if (done) begin
      active        = 0;
      last          = owner;
      pend[owner]   = 0;
      last_done_cyc = cyc;
      served_q.push_back(owner);
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_s_psel", s_psel, 0);
    chk("rst_s_penable", s_pen, 0);
    chk("rst_s_paddr", s_addr, 0);
    chk("rst_s_pwdata", s_wdata, 0);
    chk("rst_m0_pready", m0_ready, 0);
    chk("rst_m1_pready", m1_ready, 0);
    chk("rst_m1_prdata", m1_rdata, 0);
    m_psel = '{default: 1'b0};
    m_pen  = '{default: 1'b0};
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    active = 0;
    last   = 1;
    pend   = '{default: 0};
  endtask

  task automatic drain();
    want = '{default: 0};
    for (int i = 0; i < 40 && (active || pend[0] || pend[1]); i++) step();
    chk("drain_idle", {30'd0, pend[1], pend[0]} | {31'd0, active}, 0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    do_reset();

    // m0 writes 0xFF to 0x008 alone, zero-wait slave
    want[0] = 1; nxt_addr[0] = 12'h008; nxt_wdata[0] = 32'h0000_00FF; nxt_write[0] = 1'b1;
    dir_waits = 0; dir_rdata = '0;
    step();
    want[0] = 0;
    chk("d1_c0_s_psel", s_psel, 0);
    step();
    chk("d1_c1_s_psel", s_psel, 1);
    chk("d1_c1_s_penable", s_pen, 0);
    chk("d1_c1_s_paddr", s_addr, 32'h008);
    chk("d1_c1_s_pwdata", s_wdata, 32'h0000_00FF);
    chk("d1_c1_s_pwrite", s_write, 1);
    step();
    chk("d1_c2_s_penable", s_pen, 1);
    chk("d1_c2_m0_pready", m0_ready, 1);
    chk("d1_c2_m1_pready", m1_ready, 0);
    chk("d1_c2_m1_prdata", m1_rdata, 0);
    chk("d1_c2_m1_pslverr", m1_err, 0);
    step();
    chk("d1_c3_s_psel", s_psel, 0);

    // Both masters request together after reset: strict alternation
    do_reset();
    served_q.delete();
    want[0] = 1; want[1] = 1;
    nxt_addr[1] = 12'h004; nxt_wdata[1] = 32'h0000_0055; nxt_write[1] = 1'b1;
    for (int i = 0; i < 60 && served_q.size() < 4; i++) step();
    chk("d2_served_count", (served_q.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("d2_order%0d", i), (served_q.size() > i) ? served_q[i] : -1, exp_order[i]);
    drain();

    // m1 read of 0x018 with three slave wait states
    want[1] = 1; nxt_addr[1] = 12'h018; nxt_write[1] = 1'b0;
    dir_waits = 3; dir_rdata = 32'hA5A5_0001;
    step();
    want[1] = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) chk("d3_c4_m1_pready", m1_ready, 0);
    end
    chk("d3_c5_m1_pready", m1_ready, 1);
    chk("d3_c5_m1_prdata", m1_rdata, 32'hA5A5_0001);
    chk("d3_c5_m1_pslverr", m1_err, 0);
    step();

    // Slave never ready: timeout after four stalled ACCESS cycles
    want[0] = 1; nxt_addr[0] = 12'h00C; nxt_write[0] = 1'b0;
    dir_waits = 100; dir_rdata = 32'hDEAD_BEEF;
    step();
    want[0] = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) begin
        chk("d4_c5_m0_pready", m0_ready, 0);
        chk("d4_c5_s_psel", s_psel, 1);
      end
    end
    chk("d4_c6_m0_pready", m0_ready, 1);
    chk("d4_c6_m0_pslverr", m0_err, 1);
    chk("d4_c6_m0_prdata", m0_rdata, 0);
    chk("d4_c6_s_psel", s_psel, 0);
    step();
    chk("d4_c7_s_psel", s_psel, 0);
    chk("d4_c7_s_penable", s_pen, 0);

    // Reset during ACCESS; the still-pending m1 request then completes
    want[1] = 1; nxt_addr[1] = 12'h018; dir_waits = 3; dir_rdata = 32'h0BAD_F00D;
    step(); step(); step();
    do_reset();
    served_q.delete();
    step();
    c0 = cyc;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (served_q.size() > 0) found = 1;
      else step();
    end
    chk("d5_m1_completed", found, 1);
    chk("d5_m1_owner", (served_q.size() > 0) ? served_q[0] : -1, 1);
    chk("d5_latency", last_done_cyc - c0, 5);
    drain();

    // Randomized traffic with noisy idle inputs and random wait states
    noise = 1; rand_waits = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          want[m]      = ($urandom_range(0, 99) < 55);
          nxt_addr[m]  = AW'($urandom);
          nxt_wdata[m] = $urandom;
          nxt_write[m] = 1'($urandom_range(0, 1));
        end
      end
      step();
    end
    noise = 0; rand_waits = 0;
    drain();

    // Fixed-priority build: both request continuously, m0 always wins
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      f_psel[0] = 1'b1;
      f_psel[1] = 1'b1;
      f_pen[0]  = ((i % 3) != 0);
      f_pen[1]  = (i != 0);
      #1;
      chk("fp_m0_pready", f_m0_ready, ((i % 3) == 2) ? 1 : 0);
      chk("fp_m0_prdata", f_m0_rdata, ((i % 3) == 2) ? 32'h1234_5678 : 0);
      chk("fp_m1_pready", f_m1_ready, 0);
      chk("fp_m1_prdata", f_m1_rdata, 0);
      chk("fp_s_psel", f_s_psel, ((i % 3) != 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    f_psel = '{default: 1'b0};
    f_pen  = '{default: 1'b0};

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
